// File: rtl/rfe_pkg.sv
// Shared RM(1,5) constants, FSM state encodings and the first-order pattern
// generator used by the reproduction stage and by generator-side checks.
package rfe_pkg;

  localparam int RM_N = 32;
  localparam int RM_K = 6;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SCAN   = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // pattern[u] = parity(mask & u): the codeword of info bits {mask, 0}
  function automatic logic [RM_N-1:0] rm_pattern(input logic [4:0] mask);
    logic [RM_N-1:0] p;
    for (int u = 0; u < RM_N; u++) begin
      p[u] = ^(mask & u[4:0]);
    end
    return p;
  endfunction

endpackage

// File: rtl/device_rfe_rep_if.sv
// Bundle of the reproduction-stage data/handshake signals; master drives start
// and readouts, slave (the decoder) returns the recovered word. RFE_REP_ERRCNT_EN adds error counts.
interface device_rfe_rep_if #(
  parameter int BLOCKS = 22
);
  import rfe_pkg::*;

  logic                     start;
  logic [BLOCKS*RM_N-1:0]   rprime_noisy;
  logic [BLOCKS*RM_N-1:0]   helper_data;
  logic [BLOCKS*RM_K-1:0]   x_rec;
  logic [BLOCKS-1:0]        key;
  logic                     busy;
  logic                     complete;
`ifdef RFE_REP_ERRCNT_EN
  logic [BLOCKS*6-1:0]      blk_errs;
  logic [15:0]              total_errs;

  modport master (
    output start, rprime_noisy, helper_data,
    input  x_rec, key, busy, complete, blk_errs, total_errs
  );
  modport slave (
    input  start, rprime_noisy, helper_data,
    output x_rec, key, busy, complete, blk_errs, total_errs
  );
`else
  modport master (
    output start, rprime_noisy, helper_data,
    input  x_rec, key, busy, complete
  );
  modport slave (
    input  start, rprime_noisy, helper_data,
    output x_rec, key, busy, complete
  );
`endif

endinterface

// File: rtl/rm_corr_unit.sv
// Combinational RM(1,5) correlator: C = 32 - 2*dist(y_blk, pattern(mask)).
// Zero latency, no flow control; shared across all candidates by the FSM.
module rm_corr_unit
  import rfe_pkg::*;
(
  input  logic [RM_N-1:0]   y_blk,
  input  logic [4:0]        mask,
  output logic signed [6:0] corr
);

  logic [RM_N-1:0] diff;
  logic [5:0]      pop;

  always_comb begin
    diff = y_blk ^ rm_pattern(mask);
    pop  = 6'($countones(diff));
    // 7-bit wraparound yields the signed result directly (-32..+32)
    corr = $signed(7'd32 - {pop, 1'b0});
  end

endmodule

// File: rtl/device_rfe_rep.sv
// Fuzzy-extractor reproduction: serial ML RM(1,5) decode, 33 cycles/block, complete at E+2+33*BLOCKS.
// No backpressure; start edges outside IDLE are dropped. RFE_REP_ERRCNT_EN adds blk_errs/total_errs.
module device_rfe_rep
  import rfe_pkg::*;
#(
  parameter int BLOCKS = 22,
  parameter int N      = RM_N,
  parameter int K      = RM_K
) (
  input  logic               clk,
  input  logic               rst_n,
  device_rfe_rep_if.slave    bus
);

  localparam int BLK_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

  logic [2:0]          state_q, state_d;
  logic                start_prev_q, start_prev_d;
  logic [BLOCKS*N-1:0] y_q, y_d;
  logic [BLK_W-1:0]    blk_idx_q, blk_idx_d;
  logic [4:0]          mask_q, mask_d;
  logic [5:0]          best_abs_q, best_abs_d;
  logic [4:0]          best_mask_q, best_mask_d;
  logic                best_neg_q, best_neg_d;
  logic [BLOCKS*K-1:0] x_int_q, x_int_d;
  logic [BLOCKS*K-1:0] x_rec_q, x_rec_d;
  logic [BLOCKS-1:0]   key_q, key_d;
  logic                complete_q, complete_d;

  logic [N-1:0]        y_blk;
  logic signed [6:0]   corr;
  logic [6:0]          corr_neg;
  logic [5:0]          corr_abs;
  logic                start_rise;
  logic [BLOCKS-1:0]   key_calc;

`ifdef RFE_REP_ERRCNT_EN
  logic [BLOCKS*6-1:0] errs_int_q, errs_int_d;
  logic [BLOCKS*6-1:0] blk_errs_q, blk_errs_d;
  logic [15:0]         total_errs_q, total_errs_d;
  logic [15:0]         total_calc;
  logic [16:0]         total_acc;
`endif

  assign start_rise = bus.start & ~start_prev_q;
  assign y_blk      = y_q[blk_idx_q*N +: N];

  rm_corr_unit u_corr (
    .y_blk (y_blk),
    .mask  (mask_q),
    .corr  (corr)
  );

  always_comb begin
    corr_neg = 7'd0 - corr;
    corr_abs = corr[6] ? corr_neg[5:0] : corr[5:0];
  end

  // Key bit is the majority of the block's six recovered bits; 3/3 resolves to 0.
  always_comb begin
    key_calc = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      key_calc[b] = ($countones(x_int_q[b*K +: K]) >= 4);
    end
  end

`ifdef RFE_REP_ERRCNT_EN
  always_comb begin
    total_acc = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      total_acc = total_acc + 17'(errs_int_q[b*6 +: 6]);
      if (total_acc[16]) total_acc = 17'h0FFFF;
    end
    total_calc = total_acc[15:0];
  end
`endif

  always_comb begin
    state_d      = state_q;
    start_prev_d = bus.start;
    y_d          = y_q;
    blk_idx_d    = blk_idx_q;
    mask_d       = mask_q;
    best_abs_d   = best_abs_q;
    best_mask_d  = best_mask_q;
    best_neg_d   = best_neg_q;
    x_int_d      = x_int_q;
    x_rec_d      = x_rec_q;
    key_d        = key_q;
    complete_d   = 1'b0;
`ifdef RFE_REP_ERRCNT_EN
    errs_int_d   = errs_int_q;
    blk_errs_d   = blk_errs_q;
    total_errs_d = total_errs_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_rise) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        y_d       = bus.rprime_noisy ^ bus.helper_data;
        blk_idx_d = '0;
        mask_d    = '0;
        state_d   = ST_SCAN;
      end
      ST_SCAN: begin
        // Strict compare keeps the lowest mask on ties.
        if (mask_q == 5'd0 || corr_abs > best_abs_q) begin
          best_abs_d  = corr_abs;
          best_mask_d = mask_q;
          best_neg_d  = corr[6];
        end
        if (mask_q == 5'd31) state_d = ST_COMMIT;
        else                 mask_d  = mask_q + 5'd1;
      end
      ST_COMMIT: begin
        x_int_d[blk_idx_q*K +: K] = {best_mask_q, best_neg_q};
`ifdef RFE_REP_ERRCNT_EN
        errs_int_d[blk_idx_q*6 +: 6] = (6'd32 - best_abs_q) >> 1;
`endif
        mask_d = '0;
        if (blk_idx_q == BLK_W'(BLOCKS-1)) begin
          state_d = ST_DONE;
        end else begin
          blk_idx_d = blk_idx_q + 1'b1;
          state_d   = ST_SCAN;
        end
      end
      ST_DONE: begin
        x_rec_d    = x_int_q;
        key_d      = key_calc;
        complete_d = 1'b1;
`ifdef RFE_REP_ERRCNT_EN
        blk_errs_d   = errs_int_q;
        total_errs_d = total_calc;
`endif
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      y_q          <= '0;
      blk_idx_q    <= '0;
      mask_q       <= '0;
      best_abs_q   <= '0;
      best_mask_q  <= '0;
      best_neg_q   <= 1'b0;
      x_int_q      <= '0;
      x_rec_q      <= '0;
      key_q        <= '0;
      complete_q   <= 1'b0;
`ifdef RFE_REP_ERRCNT_EN
      errs_int_q   <= '0;
      blk_errs_q   <= '0;
      total_errs_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      y_q          <= y_d;
      blk_idx_q    <= blk_idx_d;
      mask_q       <= mask_d;
      best_abs_q   <= best_abs_d;
      best_mask_q  <= best_mask_d;
      best_neg_q   <= best_neg_d;
      x_int_q      <= x_int_d;
      x_rec_q      <= x_rec_d;
      key_q        <= key_d;
      complete_q   <= complete_d;
`ifdef RFE_REP_ERRCNT_EN
      errs_int_q   <= errs_int_d;
      blk_errs_q   <= blk_errs_d;
      total_errs_q <= total_errs_d;
`endif
    end
  end

  assign bus.x_rec    = x_rec_q;
  assign bus.key      = key_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.complete = complete_q;
`ifdef RFE_REP_ERRCNT_EN
  assign bus.blk_errs   = blk_errs_q;
  assign bus.total_errs = total_errs_q;
`endif

endmodule

// File: tb/tb_device_rfe_rep.sv
// Scoreboard bench for device_rfe_rep: expected decode results are queued at start
// and compared on complete, plus directed checks of the known-answer cases.
module tb_device_rfe_rep;

  localparam int BLOCKS = 22;
  localparam int N      = 32;
  localparam int K      = 6;
  localparam int LAT    = 2 + 33*BLOCKS;
  localparam int W      = BLOCKS*N;

  typedef struct {
    logic [BLOCKS*K-1:0] x;
    logic [BLOCKS-1:0]   k;
    logic [BLOCKS*6-1:0] e;
    logic [15:0]         t;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  device_rfe_rep_if #(.BLOCKS(BLOCKS)) bus ();

  device_rfe_rep #(.BLOCKS(BLOCKS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < BLOCKS; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Codeword of info bits a: a[0] is the constant term, a[5:1] the linear mask.
  function automatic logic [N-1:0] encode(input logic [K-1:0] a);
    logic [N-1:0] c;
    for (int u = 0; u < N; u++) begin
      c[u] = a[0];
      for (int j = 0; j < 5; j++) c[u] = c[u] ^ (a[j+1] & u[j]);
    end
    return c;
  endfunction

  // Reference ML decoder using a +/-1 correlation sum over every candidate.
  task automatic model(input logic [W-1:0] rp, input logic [W-1:0] hd, output exp_t r);
    logic [W-1:0] yy;
    logic [N-1:0] y;
    logic         p;
    int           best, corr, a, bm, tot;
    logic         bn;
    yy  = rp ^ hd;
    r.x = '0; r.k = '0; r.e = '0; tot = 0;
    for (int b = 0; b < BLOCKS; b++) begin
      y = yy[b*N +: N];
      best = -1; bm = 0; bn = 1'b0;
      for (int m = 0; m < 32; m++) begin
        corr = 0;
        for (int u = 0; u < N; u++) begin
          p = ^(m[4:0] & u[4:0]);
          corr += (y[u] == p) ? 1 : -1;
        end
        a = (corr < 0) ? -corr : corr;
        if (a > best) begin
          best = a; bm = m; bn = (corr < 0);
        end
      end
      r.x[b*K +: K] = {bm[4:0], bn};
      r.k[b]        = ($countones(r.x[b*K +: K]) >= 4);
      r.e[b*6 +: 6] = 6'((32 - best) / 2);
      tot += (32 - best) / 2;
    end
    r.t = (tot > 65535) ? 16'hFFFF : 16'(tot);
  endtask

  task automatic run_decode(input logic [W-1:0] rp, input logic [W-1:0] hd,
                            input int repulse_at, input int reset_at);
    exp_t e;
    int   cyc;
    int   extra;
    @(negedge clk);
    bus.rprime_noisy = rp;
    bus.helper_data  = hd;
    bus.start        = 1'b1;
    model(rp, hd, e);
    sb_q.push_back(e);
    @(posedge clk);
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) begin
        bus.rprime_noisy = rand_vec();
        bus.helper_data  = rand_vec();
      end
      if (cyc == repulse_at)     bus.start = 1'b0;
      if (cyc == repulse_at + 2) bus.start = 1'b1;
      if (cyc == reset_at) begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        #1;
        check_eq("rst_mid_x_rec", bus.x_rec, '0);
        check_eq("rst_mid_key", bus.key, '0);
        check_eq("rst_mid_busy", bus.busy, '0);
        check_eq("rst_mid_complete", bus.complete, '0);
        void'(sb_q.pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (bus.complete) break;
    end
    check_eq("latency", cyc, LAT);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_eq("x_rec", bus.x_rec, e.x);
      check_eq("key", bus.key, e.k);
`ifdef RFE_REP_ERRCNT_EN
      check_eq("blk_errs", bus.blk_errs, e.e);
      check_eq("total_errs", bus.total_errs, e.t);
`endif
    end
    check_eq("busy_after", bus.busy, '0);
    // start is still held high here: no second decode may follow.
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.complete || bus.busy) extra++;
    end
    check_eq("no_retrigger", extra, 0);
    check_eq("x_rec_hold", bus.x_rec, e.x);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0]   rp, hd, noisy, cw;
    logic [K-1:0]   a;
    logic [N-1:0]   tie;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.rprime_noisy = '0;
    bus.helper_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_x_rec", bus.x_rec, '0);
    check_eq("rst_key", bus.key, '0);
    check_eq("rst_busy", bus.busy, '0);
    check_eq("rst_complete", bus.complete, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero readout and helper data.
    run_decode('0, '0, -1, -1);
    check_eq("zero_x_rec", bus.x_rec, '0);
    check_eq("zero_key", bus.key, '0);

    // Generator loopback: alternating all-ones/all-zeros info words, 7 flips in block 0.
    rp = rand_vec();
    cw = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      a = (b % 2 == 0) ? 6'h3F : 6'h00;
      cw[b*N +: N] = encode(a);
    end
    hd    = cw ^ rp;
    noisy = rp;
    for (int i = 0; i < 7; i++) noisy[i*3] = ~noisy[i*3];
    run_decode(noisy, hd, -1, -1);
    check_eq("loop_blk0", bus.x_rec[5:0], 6'h3F);
    check_eq("loop_blk1", bus.x_rec[11:6], 6'h00);
    check_eq("loop_key", bus.key[3:0], 4'b0101);
`ifdef RFE_REP_ERRCNT_EN
    check_eq("loop_errs0", bus.blk_errs[5:0], 6'd7);
`endif

    // Tie between mask 0 and mask 1 must keep mask 0.
    tie = '0;
    for (int u = 1; u < 16; u += 2) tie[u] = 1'b1;
    rp = '0;
    rp[N-1:0] = tie;
    run_decode(rp, '0, -1, -1);
    check_eq("tie_blk0", bus.x_rec[5:0], 6'h00);
`ifdef RFE_REP_ERRCNT_EN
    check_eq("tie_errs0", bus.blk_errs[5:0], 6'd8);
`endif

    // Complement of the zero codeword.
    rp = '0;
    rp[N-1:0] = 32'hFFFF_FFFF;
    run_decode(rp, '0, -1, -1);
    check_eq("cmp_blk0", bus.x_rec[5:0], 6'b000001);
    check_eq("cmp_key0", bus.key[0], 1'b0);

    // start re-pulsed mid-scan is ignored.
    run_decode(rand_vec(), rand_vec(), 100, -1);

    // Reset mid-operation, then a full run from scratch.
    run_decode(rand_vec(), rand_vec(), -1, 300);
    repeat (2) @(negedge clk);
    run_decode(rand_vec(), rand_vec(), -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/device_rfe_rep.md
# device_rfe_rep

Reproduction stage of the PUF fuzzy extractor, directly downstream of `device_rfe_gen`. It consumes the stored `helper_data` and a fresh, noisy, replicated PUF readout. For each block it forms y = R'' XOR H and runs a serial maximum-likelihood RM(1,5) decode over all 32 first-order candidates. It outputs the recovered information word and one key bit per block.

## Interface
- `BLOCKS`, 22, number of RM(1,5) blocks (same value as the generator)
- `N`, 32, codeword length, fixed for RM(1,5)
- `K`, 6, information bits per block, fixed for RM(1,5)

Ports:
- `clk`  in  1  system clock; one clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  rising edge (registered `start_d` detect) launches a decode
- `rprime_noisy`  in  BLOCKS*N  replicated noisy PUF readout, sampled in LOAD
- `helper_data`  in  BLOCKS*N  stored helper data, sampled in LOAD
- `x_rec`  out  BLOCKS*K  recovered info word, block b at [b*K +: K]
- `key`  out  BLOCKS  per-block key bit, the majority of the block's K recovered bits
- `busy`  out  1  high from LOAD through DONE inclusive
- `complete`  out  1  one-cycle pulse when `x_rec`/`key` are updated

## Operation
- States: IDLE, LOAD, SCAN, COMMIT, DONE.
- IDLE→LOAD on a `start` rising edge. A `start` edge in any other state is ignored.
- LOAD, one cycle:
  - latch y_reg = `rprime_noisy` XOR `helper_data`
  - blk_idx=0, mask=0
- SCAN, 32 cycles per block; each cycle evaluates candidate `mask` (0..31) against block blk_idx:
  - pattern[u] = parity(mask & u[4:0]), for u=0..31
  - C = 32 − 2·popcount(y_blk XOR pattern), signed 7-bit, range −32..+32
  - mask 0 loads best_abs=|C|, best_mask=0 and best_neg=(C<0) unconditionally
  - for later masks, replace the best only if |C| > best_abs (strict), so ties keep the lowest mask
  - leave SCAN after mask 31
- COMMIT, one cycle:
  - write x_int[blk_idx*K +: K] = {best_mask, best_neg}, so a[0]=best_neg and a[j+1]=best_mask[j], matching `rm_encoder` bit order
  - if blk_idx==BLOCKS−1 go to DONE; else blk_idx+1, mask=0, go to SCAN
- DONE, one cycle:
  - `x_rec`<=x_int
  - `key[b]`<=(popcount(x_int block b) ≥ 4); a 3/3 tie gives 0
  - `complete`<=1, then go to IDLE
- Width rules:
  - popcount is 6-bit (0..32), |C| is 6-bit
  - blk_idx is $clog2(BLOCKS) bits; mask is 5 bits and wraps 31→0 only on a COMMIT transition
- `x_rec` and `key` hold their last values between decodes.

## Timing
- Reset value of every output is 0: `x_rec`, `key`, `busy`, `complete`. The FSM resets to IDLE.
- Reset mid-operation: everything returns immediately to the reset state, with no partial update of `x_rec`/`key`.
- Latency: the `start` edge is sampled at clock edge E. `complete` is high in the cycle after edge E + 2 + 33·BLOCKS, which is E+728 for BLOCKS=22.
- Inputs are only required stable in the LOAD cycle. Changes during SCAN do not affect the result.
- `start` held high continuously produces a single decode; a new edge is needed after DONE.

## Configuration
- `RFE_REP_ERRCNT_EN`
  - Defined: adds outputs `blk_errs` (BLOCKS*6, per block (32−best_abs)/2, corrected-bit count) and `total_errs` (16-bit saturating sum across blocks).
  - Both outputs update in DONE together with `x_rec` and reset to 0.
  - Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `rfe_pkg`:
  - localparams RM_N=32, RM_K=6
  - FSM state enum
  - function `rm_pattern(mask)` returning the 32-bit first-order pattern, also usable by generator checks
- One sub-module `rm_corr_unit`: combinational, takes y_blk (32) and mask (5), returns signed C (7). It is instantiated once, and the FSM time-multiplexes it.

## Test plan
- All-zero `rprime_noisy` and `helper_data`, start at edge 0 → `complete` at cycle 728; `x_rec`=0, `key`=0; `busy` low after DONE.
- Generator loopback: TRNG bits 1,0,1… with `rprime_noisy`=rprime and 7 bit flips in block 0 → `x_rec` block0=6'h3F, block1=6'h00; `key`=alternating 1,0…; errcnt block0=7 when enabled.
- Tie: block0 y has ones only at u∈{1,3,…,15} → |C|=16 for mask 0 and mask 1 → mask 0 kept, block0 a=0; errcnt=8.
- Complement: block0 y=32'hFFFF_FFFF → C(mask0)=−32 → a=6'b000001, `key[0]`=0.
- Robustness:
  - `start` re-pulsed at cycle 100 → ignored, single `complete` at 728
  - `rst_n` asserted at cycle 300 → all outputs 0, IDLE; the next start gives a full 728-cycle run.
